// File: rtl/vvalu_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vvalu_cfg_pkg : shared types and constants for the VVALU firmware loader
// Revision      : 1.0
// ---------------------------------------------------------------------------
package vvalu_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_PENDING = 2'd3
  } cfg_state_t;

  localparam int CFG_PKT_BYTES = 7;
  localparam int NUM_FIELDS    = CFG_PKT_BYTES - 1;

  localparam int FLD_OP         = 0;
  localparam int FLD_ADDR_RD    = 1;
  localparam int FLD_COND       = 2;
  localparam int FLD_CACHE      = 3;
  localparam int FLD_CACHE_ADDR = 4;
  localparam int FLD_CACHE_COND = 5;

endpackage
`default_nettype wire

// File: rtl/vvalu_fw_config_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vvalu_fw_config_loader : byte-serial loader for the VVALU firmware chain tables
// Revision               : 1.0
// ---------------------------------------------------------------------------
module vvalu_fw_config_loader
  import vvalu_cfg_pkg::*;
#(
  parameter int                      MAX_CHAINS                  = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID          = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_OP         = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_ADDR_RD    = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND       = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE      = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE_ADDR = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_CACHE_COND = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tracing,
  input  logic                      config_valid,
  input  logic [7:0]                configId,
  input  logic [7:0]                configData,
  output logic                      config_ready,
  output logic [8*MAX_CHAINS-1:0]   firmware_op,
  output logic [8*MAX_CHAINS-1:0]   firmware_addr_rd,
  output logic [8*MAX_CHAINS-1:0]   firmware_cond,
  output logic [8*MAX_CHAINS-1:0]   firmware_cache,
  output logic [8*MAX_CHAINS-1:0]   firmware_cache_addr,
  output logic [8*MAX_CHAINS-1:0]   firmware_cache_cond,
  output logic                      cfg_done,
  output logic                      cfg_error
);

  localparam int IDX_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  cfg_state_t       r_state, w_next_state;
  logic [2:0]       r_count;
  logic [IDX_W-1:0] r_index;
  logic [7:0]       r_shadow [NUM_FIELDS];
  logic             r_error, r_done;
  logic             w_id_match, w_accept, w_abort, w_commit, w_idx_ok, w_last;

  always_comb begin
    w_id_match   = (configId == PERSONAL_CONFIG_ID);
    config_ready = (r_state != ST_PENDING);
    w_accept     = config_valid && config_ready && w_id_match;
    // A foreign byte mid-packet kills the packet but is not consumed.
    w_abort      = config_valid && !w_id_match &&
                   ((r_state == ST_COLLECT) || (r_state == ST_DISCARD));
    w_commit     = (r_state == ST_PENDING) && !tracing;
    w_idx_ok     = ({24'd0, configData} < 32'(MAX_CHAINS));
    w_last       = (r_count == 3'(CFG_PKT_BYTES - 1));
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = w_idx_ok ? ST_COLLECT : ST_DISCARD;
      ST_COLLECT: if (w_abort) w_next_state = ST_IDLE;
                  else if (w_accept && w_last) w_next_state = ST_PENDING;
      ST_DISCARD: if (w_abort || (w_accept && w_last)) w_next_state = ST_IDLE;
      ST_PENDING: if (w_commit) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_index <= '0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
      for (int f = 0; f < NUM_FIELDS; f++) r_shadow[f] <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_commit;
      if (w_abort) begin
        r_error <= 1'b1;
        r_count <= '0;
      end
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_count <= 3'd1;
          if (w_idx_ok) r_index <= configData[IDX_W-1:0];
          else          r_error <= 1'b1;
        end
        ST_COLLECT: if (w_accept) begin
          for (int f = 0; f < NUM_FIELDS; f++)
            if (r_count == 3'(f + 1)) r_shadow[f] <= configData;
          r_count <= w_last ? 3'd0 : r_count + 3'd1;
        end
        ST_DISCARD: if (w_accept) r_count <= w_last ? 3'd0 : r_count + 3'd1;
        default: ;
      endcase
    end
  end

  assign cfg_done  = r_done;
  assign cfg_error = r_error;

  for (genvar c = 0; c < MAX_CHAINS; c++) begin : g_chain
    logic [7:0] r_entry [NUM_FIELDS];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_entry[FLD_OP]         <= INITIAL_FIRMWARE_OP[8*c +: 8];
        r_entry[FLD_ADDR_RD]    <= INITIAL_FIRMWARE_ADDR_RD[8*c +: 8];
        r_entry[FLD_COND]       <= INITIAL_FIRMWARE_COND[8*c +: 8];
        r_entry[FLD_CACHE]      <= INITIAL_FIRMWARE_CACHE[8*c +: 8];
        r_entry[FLD_CACHE_ADDR] <= INITIAL_FIRMWARE_CACHE_ADDR[8*c +: 8];
        r_entry[FLD_CACHE_COND] <= INITIAL_FIRMWARE_CACHE_COND[8*c +: 8];
      end else if (w_commit && (r_index == IDX_W'(c))) begin
        for (int f = 0; f < NUM_FIELDS; f++) r_entry[f] <= r_shadow[f];
      end
    end

    assign firmware_op[8*c +: 8]         = r_entry[FLD_OP];
    assign firmware_addr_rd[8*c +: 8]    = r_entry[FLD_ADDR_RD];
    assign firmware_cond[8*c +: 8]       = r_entry[FLD_COND];
    assign firmware_cache[8*c +: 8]      = r_entry[FLD_CACHE];
    assign firmware_cache_addr[8*c +: 8] = r_entry[FLD_CACHE_ADDR];
    assign firmware_cache_cond[8*c +: 8] = r_entry[FLD_CACHE_COND];
  end

endmodule
`default_nettype wire
